// File: rtl/dma_write_sched.sv
// dma_write_sched: round-robin arbiter sharing one PCIe DMA write engine among
// NREQ split channels. It grants one channel at a time and issues a one-cycle
// start. The grant is held until the engine reports end. A MIN_GAP idle window
// follows every transfer before the next arbitration.
// Optional macro DMA_WR_TIMEOUT_EN builds a watchdog. The watchdog aborts a
// transfer whose end never arrives and sets a sticky timeout_err.
module dma_write_sched #(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 16,
    parameter int MIN_GAP = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk_pcie,
    input  logic                  rst_pcie,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic                  dma_write_start,
    output logic [LEN_W-1:0]      dma_write_len,
    input  logic                  dma_write_end,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = $clog2(MIN_GAP + 2);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     cur_q, cur_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;

    logic [PW-1:0]     win;
    logic [LEN_W-1:0]  win_len;
    logic              finish;
    logic [PW-1:0]     fin_idx;

`ifdef DMA_WR_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]    wd_q, wd_d;
    logic              terr_q, terr_d;
`endif

    // Successor of a channel index, wrapping at NREQ (NREQ need not be a power of 2).
    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
        return (w == PW'(NREQ - 1)) ? '0 : w + 1'b1;
    endfunction

    // Winner: first requesting channel at or above the pointer, wrapping.
    // Scan from the far end so the nearest hit is the last assignment.
    always_comb begin
        logic [PW:0] s;
        win = '0;
        s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr_q} + (PW+1)'(k);
            if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
            if (req[s[PW-1:0]]) win = s[PW-1:0];
        end
    end

    // Length field of the current winner.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) win_len = req_len[i*LEN_W +: LEN_W];
        end
    end

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        gap_d   = gap_q;
        grant_d = grant_q;
        start_d = 1'b0;
        len_d   = len_q;
        done_d  = '0;
        finish  = 1'b0;
        fin_idx = cur_q;
`ifdef DMA_WR_TIMEOUT_EN
        wd_d    = wd_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    cur_d = win;
                    if (win_len == '0) begin
                        // Nothing to move: complete at once, no engine start.
                        done_d  = ONE << win;
                        finish  = 1'b1;
                        fin_idx = win;
                    end else begin
                        grant_d = ONE << win;
                        len_d   = win_len;
                        start_d = 1'b1;
                        state_d = S_WAIT;
`ifdef DMA_WR_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                // End wins over a watchdog expiry in the same cycle.
                if (dma_write_end) begin
                    grant_d = '0;
                    done_d  = grant_q;
                    finish  = 1'b1;
`ifdef DMA_WR_TIMEOUT_EN
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    grant_d = '0;
                    terr_d  = 1'b1;
                    finish  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (gap_q <= GW'(1)) state_d = S_IDLE;
                else                 gap_d   = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion (normal, zero-length or abort) advances the pointer.
        if (finish) begin
            ptr_d   = rr_next(fin_idx);
            gap_d   = GW'(MIN_GAP);
            state_d = (MIN_GAP == 0) ? S_IDLE : S_GAP;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_pcie or posedge rst_pcie) begin
        if (rst_pcie) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            len_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            start_q <= start_d;
            len_q   <= len_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DMA_WR_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk_pcie or posedge rst_pcie) begin
        if (rst_pcie) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant           = grant_q;
    assign dma_write_start = start_q;
    assign dma_write_len   = len_q;
    assign done            = done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_dma_write_sched.sv
// Scoreboard bench for dma_write_sched: stimulus pushes expected start/done/
// busy-fall/timeout events with their cycle numbers; a monitor pops and
// compares whenever the DUT shows the corresponding output.
module tb_dma_write_sched;

    localparam int NREQ = 4, LEN_W = 16, MIN_GAP = 8, TIMEOUT = 16;

    logic                  clk_pcie = 1'b0;
    logic                  rst_pcie = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic                  dma_write_end = 1'b0;
    logic [NREQ-1:0]       grant, done;
    logic                  dma_write_start, busy, timeout_err;
    logic [LEN_W-1:0]      dma_write_len;

    dma_write_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk_pcie(clk_pcie), .rst_pcie(rst_pcie), .req(req), .req_len(req_len),
        .grant(grant), .dma_write_start(dma_write_start), .dma_write_len(dma_write_len),
        .dma_write_end(dma_write_end), .done(done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk_pcie = ~clk_pcie;

    int cyc = 0;
    always @(posedge clk_pcie) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    typedef struct { int c; logic [NREQ-1:0] g; logic [LEN_W-1:0] l; } ev_t;
    ev_t start_q[$];
    ev_t done_q[$];
    int  busy_q[$];
    int  terr_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    task automatic tick;
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_len(input int ch, input logic [LEN_W-1:0] l);
        req_len[ch*LEN_W +: LEN_W] = l;
    endtask

    function automatic ev_t mk(input int c, input logic [NREQ-1:0] g, input logic [LEN_W-1:0] l);
        ev_t e;
        e.c = c; e.g = g; e.l = l;
        return e;
    endfunction

    // Monitor: compare every observed DUT event against the scoreboard.
    logic busy_prev = 1'b0, terr_prev = 1'b0;
    always @(negedge clk_pcie) begin : mon
        ev_t e;
        int  c;
        if (rst_pcie) begin
            busy_prev = 1'b0;
            terr_prev = 1'b0;
        end else begin
            if (dma_write_start) begin
                if (start_q.size() == 0) flag("unexpected_start");
                else begin
                    e = start_q.pop_front();
                    check("start_cycle", cyc, e.c);
                    check("start_grant", grant, e.g);
                    check("start_len", dma_write_len, e.l);
                end
            end
            if (done != '0) begin
                if (done_q.size() == 0) flag("unexpected_done");
                else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e.c);
                    check("done_value", done, e.g);
                    check("done_grant_clear", grant, 0);
                end
            end
            if (busy_prev && !busy) begin
                if (busy_q.size() == 0) flag("unexpected_busy_fall");
                else begin
                    c = busy_q.pop_front();
                    check("busy_fall_cycle", cyc, c);
                end
            end
            if (!terr_prev && timeout_err) begin
                if (terr_q.size() == 0) flag("unexpected_timeout_err");
                else begin
                    c = terr_q.pop_front();
                    check("timeout_cycle", cyc, c);
                    check("timeout_grant_clear", grant, 0);
                end
            end
            busy_prev = busy;
            terr_prev = timeout_err;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, s;
        logic [LEN_W-1:0] lens [NREQ];
        lens[0] = 16'h0011; lens[1] = 16'h0022; lens[2] = 16'h0033; lens[3] = 16'h0044;

        // Reset state
        repeat (3) tick();
        rst_pcie = 1'b0;
        check("rst_grant", grant, 0);
        check("rst_start", dma_write_start, 0);
        check("rst_len", dma_write_len, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        tick(); tick();

        // Single request, end 20 cycles after start
        n = cyc;
        req = 4'b0010; set_len(1, 16'h0100);
        start_q.push_back(mk(n + 1, 4'b0010, 16'h0100));
        done_q.push_back(mk(n + 22, 4'b0010, '0));
        busy_q.push_back(n + 30);
        wait_to(n + 21);
        dma_write_end = 1'b1; tick(); dma_write_end = 1'b0; req = '0;
        wait_to(n + 32);

        // Spurious end in idle, then end coincident with start (ch0; pointer at 2)
        dma_write_end = 1'b1; tick(); dma_write_end = 1'b0; tick(); tick();
        n = cyc;
        req = 4'b0001; set_len(0, 16'h0033);
        start_q.push_back(mk(n + 1, 4'b0001, 16'h0033));
        done_q.push_back(mk(n + 2, 4'b0001, '0));
        busy_q.push_back(n + 10);
        tick(); dma_write_end = 1'b1;
        tick(); dma_write_end = 1'b0; req = '0;
        wait_to(n + 12);

        // Zero length on ch2: done next cycle, no start, then gap
        n = cyc;
        req = 4'b0100; set_len(2, 16'h0000);
        done_q.push_back(mk(n + 1, 4'b0100, '0));
        busy_q.push_back(n + 9);
        tick(); req = '0;
        wait_to(n + 11);

        // Reset mid-transfer: outputs clear at once, no done, pointer back to 0
        n = cyc;
        req = 4'b0100; set_len(2, 16'h0005);
        start_q.push_back(mk(n + 1, 4'b0100, 16'h0005));
        wait_to(n + 4);
        rst_pcie = 1'b1;
        #2;
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        tick(); req = '0; tick();
        rst_pcie = 1'b0;
        tick(); tick();

        // Fairness: all four held, engine ends 5 cycles after each start
        n = cyc;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, lens[i]);
        for (int k = 0; k < 5; k++) begin
            s = n + 1 + 15 * k;
            start_q.push_back(mk(s, 4'b0001 << (k % 4), lens[k % 4]));
            done_q.push_back(mk(s + 6, 4'b0001 << (k % 4), '0));
            busy_q.push_back(s + 14);
        end
        for (int k = 0; k < 5; k++) begin
            s = n + 1 + 15 * k;
            wait_to(s + 5);
            dma_write_end = 1'b1; tick(); dma_write_end = 1'b0;
            if (k == 4) req = '0;
        end
        wait_to(n + 1 + 60 + 16);

`ifdef DMA_WR_TIMEOUT_EN
        // End on the 16th wait cycle beats the watchdog (ch1; pointer at 1)
        n = cyc;
        req = 4'b0010; set_len(1, 16'h0077);
        start_q.push_back(mk(n + 1, 4'b0010, 16'h0077));
        done_q.push_back(mk(n + 17, 4'b0010, '0));
        busy_q.push_back(n + 25);
        wait_to(n + 16);
        dma_write_end = 1'b1; tick(); dma_write_end = 1'b0; req = '0;
        check("late_end_terr", timeout_err, 0);
        wait_to(n + 27);

        // No end: abort after 16 cycles, no done, ch3 granted after the gap
        n = cyc;
        req = 4'b1100; set_len(2, 16'h0055); set_len(3, 16'h0066);
        start_q.push_back(mk(n + 1, 4'b0100, 16'h0055));
        terr_q.push_back(n + 17);
        busy_q.push_back(n + 25);
        start_q.push_back(mk(n + 26, 4'b1000, 16'h0066));
        done_q.push_back(mk(n + 30, 4'b1000, '0));
        busy_q.push_back(n + 38);
        wait_to(n + 17); req = 4'b1000;
        wait_to(n + 29);
        dma_write_end = 1'b1; tick(); dma_write_end = 1'b0; req = '0;
        wait_to(n + 40);
        check("final_terr", timeout_err, 1);
`else
        check("final_terr", timeout_err, 0);
`endif

        // Everything expected must have been observed
        check("start_q_empty", start_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("busy_q_empty", busy_q.size(), 0);
        check("terr_q_empty", terr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
